div_scan_ctrl: RTL and testbench

- Sequencer for the 4-bit divisibility datapath (divisible-by-3-or-4 SOP block).
- On a start request it walks an inclusive operand range lo..hi, one value per clock, and drives the datapath inputs.
- It samples the datapath's div result every cycle and accumulates a hit count, a hit bitmap and the first and last hit values.
- It sits between a host/test sequencer and an external divisibility instance. It never re-implements the divisibility function.

---
 rtl/div_scan_if.sv | 21 ++
 rtl/div_scan_ctrl.sv | 50 +++++
 tb/tb_div_scan_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_scan_if.sv
// div_scan_if: host-side request/result bundle of the divisibility scan sequencer
interface div_scan_if #(parameter int W = 4);
  logic start;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic busy;
  logic done;
  logic err;
  logic [W:0] hit_count;
  logic [2**W-1:0] hit_map;
  logic [W-1:0] first_hit;
  logic [W-1:0] last_hit;
  modport master (
    output start, lo, hi,
    input busy, done, err, hit_count, hit_map, first_hit, last_hit
  );
  modport slave (
    input start, lo, hi,
    output busy, done, err, hit_count, hit_map, first_hit, last_hit
  );
endinterface

// File: rtl/div_scan_ctrl.sv
// div_scan_ctrl: walks lo..hi into an external divisibility datapath and accumulates its hits
module div_scan_ctrl #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst_n,
  div_scan_if.slave    bus,
  output logic [W-1:0] opnd,
  input  logic         div_in
);
  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
  state_t state, state_n;
  logic [W-1:0] hi_q;
  logic accept;
  assign accept   = state == IDLE && bus.start;
  assign bus.busy = state == SCAN;
  assign bus.done = state == FIN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (bus.start ? (bus.lo > bus.hi ? FIN : SCAN) : IDLE) :
              state == SCAN ? (opnd == hi_q ? FIN : SCAN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opnd          <= '0;
      hi_q          <= '0;
      bus.err       <= 1'b0;
      bus.hit_count <= '0;
      bus.hit_map   <= '0;
      bus.first_hit <= '0;
      bus.last_hit  <= '0;
    end else if (accept) begin
      hi_q          <= bus.hi;
      opnd          <= bus.lo > bus.hi ? opnd : bus.lo;
      bus.err       <= bus.lo > bus.hi;
      bus.hit_count <= '0;
      bus.hit_map   <= '0;
      bus.first_hit <= '0;
      bus.last_hit  <= '0;
    end else if (state == SCAN) begin
      if (div_in) begin
        bus.hit_count       <= bus.hit_count + 1'b1;
        bus.hit_map[opnd]   <= 1'b1;
        bus.last_hit        <= opnd;
        bus.first_hit       <= bus.hit_count == '0 ? opnd : bus.first_hit;
      end
      opnd <= opnd == hi_q ? opnd : opnd + 1'b1;
    end
endmodule

// File: tb/tb_div_scan_ctrl.sv
// tb_div_scan_ctrl: directed-vector self-check of div_scan_ctrl against a behavioural divisibility datapath
module tb_div_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] opnd;
  logic div_in;
  int vecs = 0;
  int errs = 0;
  int seq [0:15];
  int nb, di;
  div_scan_if #(.W(4)) bus ();
  div_scan_ctrl #(.W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .opnd(opnd), .div_in(div_in));
  assign div_in = (opnd != 4'd0) && ((opnd % 4'd3) == 4'd0 || opnd[1:0] == 2'd0);
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic scan(input logic [3:0] l, input logic [3:0] h, output int n_busy, output int done_idx);
    n_busy = 0;
    done_idx = -1;
    bus.lo = l;
    bus.hi = h;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.lo = 4'd0;
    bus.hi = 4'd15;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        done_idx = i;
        break;
      end
      if (bus.busy && n_busy < 16) seq[n_busy] = int'(opnd);
      if (bus.busy) n_busy++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.lo = 4'd0;
    bus.hi = 4'd0;
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_err", {31'd0, bus.err}, 0);
    chk("rst_count", bus.hit_count, 0);
    chk("rst_map", bus.hit_map, 0);
    chk("rst_opnd", opnd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    scan(4'd0, 4'd15, nb, di);
    chk("full_busy", nb, 16);
    chk("full_done_idx", di, 16);
    chk("full_count", bus.hit_count, 7);
    chk("full_map", bus.hit_map, 32'h9358);
    chk("full_first", bus.first_hit, 3);
    chk("full_last", bus.last_hit, 15);
    repeat (2) @(negedge clk);
    chk("full_hold_count", bus.hit_count, 7);
    chk("full_hold_map", bus.hit_map, 32'h9358);
    scan(4'd5, 4'd7, nb, di);
    chk("r57_busy", nb, 3);
    chk("r57_done_idx", di, 3);
    chk("r57_seq0", seq[0], 5);
    chk("r57_seq1", seq[1], 6);
    chk("r57_seq2", seq[2], 7);
    chk("r57_count", bus.hit_count, 1);
    chk("r57_map", bus.hit_map, 32'h0040);
    chk("r57_first", bus.first_hit, 6);
    chk("r57_last", bus.last_hit, 6);
    scan(4'd10, 4'd2, nb, di);
    chk("bad_busy", nb, 0);
    chk("bad_done_idx", di, 0);
    chk("bad_err", {31'd0, bus.err}, 1);
    chk("bad_count", bus.hit_count, 0);
    chk("bad_map", bus.hit_map, 0);
    scan(4'd9, 4'd9, nb, di);
    chk("one_busy", nb, 1);
    chk("one_done_idx", di, 1);
    chk("one_err_clr", {31'd0, bus.err}, 0);
    chk("one_count", bus.hit_count, 1);
    chk("one_map", bus.hit_map, 32'h0200);
    chk("one_first", bus.first_hit, 9);
    chk("one_last", bus.last_hit, 9);
    bus.lo = 4'd0;
    bus.hi = 4'd15;
    bus.start = 1'b1;
    @(posedge clk);
    di = -1;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        di = i;
        break;
      end
      if (bus.busy) nb++;
    end
    chk("hold_busy", nb, 16);
    chk("hold_done_idx", di, 16);
    chk("hold_count", bus.hit_count, 7);
    @(negedge clk);
    chk("hold_idle_busy", {31'd0, bus.busy}, 0);
    chk("hold_idle_count", bus.hit_count, 7);
    @(negedge clk);
    chk("hold_restart_busy", {31'd0, bus.busy}, 1);
    chk("hold_restart_clr", bus.hit_count, 0);
    chk("hold_restart_opnd", opnd, 0);
    bus.start = 1'b0;
    di = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        di = i;
        break;
      end
    end
    chk("hold_second_done", di, 15);
    @(negedge clk);
    bus.lo = 4'd0;
    bus.hi = 4'd15;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", {31'd0, bus.busy}, 1);
    chk("mid_opnd", opnd, 7);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 0);
    chk("arst_done", {31'd0, bus.done}, 0);
    chk("arst_opnd", opnd, 0);
    chk("arst_count", bus.hit_count, 0);
    chk("arst_map", bus.hit_map, 0);
    chk("arst_first", bus.first_hit, 0);
    chk("arst_last", bus.last_hit, 0);
    @(negedge clk);
    chk("arst_hold_done", {31'd0, bus.done}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", {31'd0, bus.done}, 0);
    scan(4'd12, 4'd15, nb, di);
    chk("r1215_busy", nb, 4);
    chk("r1215_done_idx", di, 4);
    chk("r1215_count", bus.hit_count, 2);
    chk("r1215_map", bus.hit_map, 32'h9000);
    chk("r1215_first", bus.first_hit, 12);
    chk("r1215_last", bus.last_hit, 15);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
